dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache. Sits between the

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_array.sv | 53 +++++
 rtl/dcache_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants and state encoding for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int CNT_W      = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_EVICT  = 2'd1;
  localparam state_t S_FILL   = 2'd2;
  localparam state_t S_FINISH = 2'd3;

  // Byte address = {tag, index, word offset, byte bit}
  function automatic int tagW(input int idxW);
    return ADDR_W - 1 - OFFSET_W - idxW;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int TAG_W = 10
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [IDX_W-1:0]                      i_rdIdx,
  output logic [TAG_W-1:0]                      o_tag,
  output logic                                  o_valid,
  output logic                                  o_dirty,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]     o_line,
  input  logic [IDX_W-1:0]                      i_wrIdx,
  input  logic                                  i_wordWe,
  input  logic [OFFSET_W-1:0]                   i_wrOff,
  input  logic [DATA_W-1:0]                     i_wrData,
  input  logic                                  i_metaWe,
  input  logic [TAG_W-1:0]                      i_metaTag,
  input  logic                                  i_metaValid,
  input  logic                                  i_metaDirty
);

  localparam int LINES = 2 ** IDX_W;

  logic [TAG_W-1:0]                  r_tag   [LINES];
  logic [LINE_WORDS-1:0][DATA_W-1:0] r_data  [LINES];
  logic [LINES-1:0]                  r_valid;
  logic [LINES-1:0]                  r_dirty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_metaWe) begin
      r_valid[i_wrIdx] <= i_metaValid;
      r_dirty[i_wrIdx] <= i_metaDirty;
    end
  end

  // Tags and data need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge i_clk) begin
    if (i_metaWe) r_tag[i_wrIdx] <= i_metaTag;
    if (i_wordWe) r_data[i_wrIdx][i_wrOff] <= i_wrData;
  end

  assign o_tag   = r_tag[i_rdIdx];
  assign o_valid = r_valid[i_rdIdx];
  assign o_dirty = r_dirty[i_rdIdx];
  assign o_line  = r_data[i_rdIdx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with evict/fill FSM.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  output logic              o_stall,
  output logic              o_hit,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int TAG_W  = tagW(IDX_W);
  localparam int IDX_LO = OFFSET_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(LINE_WORDS - 1 + RD_LAT);
  localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(RD_LAT);

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_W-1:0]     r_cnt;
  logic [TAG_W-1:0]     r_tag;
  logic [IDX_W-1:0]     r_idx;
  logic [OFFSET_W-1:0]  r_off;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_isWr;

  logic [TAG_W-1:0]     w_inTag;
  logic [IDX_W-1:0]     w_inIdx;
  logic [OFFSET_W-1:0]  w_inOff;
  logic [IDX_W-1:0]     w_lkIdx;
  logic [OFFSET_W-1:0]  w_cntOff;
  logic [OFFSET_W-1:0]  w_fillOff;
  logic                 w_inIdle;
  logic                 w_anyReq;
  logic                 w_err;
  logic                 w_req;
  logic                 w_tagHit;
  logic                 w_hit;
  logic                 w_miss;

  logic [TAG_W-1:0]                  w_arrTag;
  logic                              w_arrValid;
  logic                              w_arrDirty;
  logic [LINE_WORDS-1:0][DATA_W-1:0] w_arrLine;

  logic                 w_wordWe;
  logic [OFFSET_W-1:0]  w_wrOff;
  logic [DATA_W-1:0]    w_wrData;
  logic                 w_metaWe;
  logic [TAG_W-1:0]     w_metaTag;
  logic                 w_metaValid;
  logic                 w_metaDirty;

  assign w_inTag   = i_addr[ADDR_W-1 -: TAG_W];
  assign w_inIdx   = i_addr[IDX_LO +: IDX_W];
  assign w_inOff   = i_addr[1 +: OFFSET_W];
  assign w_cntOff  = r_cnt[OFFSET_W-1:0];
  assign w_fillOff = OFFSET_W'(r_cnt - LAT_CNT);

  // Requests are only honoured in IDLE and never while reset is held.
  assign w_inIdle = (r_state == S_IDLE) & ~i_rst;
  assign w_anyReq = i_rd | i_wr;
  assign w_err    = w_inIdle & w_anyReq & (i_addr[0] | (i_rd & i_wr));
  assign w_req    = w_inIdle & w_anyReq & ~w_err;
  assign w_tagHit = w_arrValid & (w_arrTag == w_inTag);
  assign w_hit    = w_req & w_tagHit;
  assign w_miss   = w_req & ~w_tagHit;
  assign w_lkIdx  = (r_state == S_IDLE) ? w_inIdx : r_idx;

  dcache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rdIdx     (w_lkIdx),
    .o_tag       (w_arrTag),
    .o_valid     (w_arrValid),
    .o_dirty     (w_arrDirty),
    .o_line      (w_arrLine),
    .i_wrIdx     (w_lkIdx),
    .i_wordWe    (w_wordWe),
    .i_wrOff     (w_wrOff),
    .i_wrData    (w_wrData),
    .i_metaWe    (w_metaWe),
    .i_metaTag   (w_metaTag),
    .i_metaValid (w_metaValid),
    .i_metaDirty (w_metaDirty)
  );

  always_comb begin
    w_nextState = r_state;
    o_rdata     = '0;
    o_done      = 1'b0;
    o_stall     = 1'b0;
    o_hit       = 1'b0;
    o_err       = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    w_wordWe    = 1'b0;
    w_wrOff     = '0;
    w_wrData    = '0;
    w_metaWe    = 1'b0;
    w_metaTag   = '0;
    w_metaValid = 1'b0;
    w_metaDirty = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_err) begin
          o_err  = 1'b1;
          o_done = 1'b1;
        end else if (w_hit) begin
          o_done = 1'b1;
          o_hit  = 1'b1;
          if (i_rd) begin
            o_rdata = w_arrLine[w_inOff];
          end else begin
            w_wordWe    = 1'b1;
            w_wrOff     = w_inOff;
            w_wrData    = i_wdata;
            w_metaWe    = 1'b1;
            w_metaTag   = w_inTag;
            w_metaValid = 1'b1;
            w_metaDirty = 1'b1;
          end
        end else if (w_miss) begin
          o_stall     = 1'b1;
          w_nextState = (w_arrValid & w_arrDirty) ? S_EVICT : S_FILL;
        end
      end
      // Victim tag is still in the array until the fill completes.
      S_EVICT: begin
        o_stall     = 1'b1;
        o_mem_wr    = 1'b1;
        o_mem_addr  = {w_arrTag, r_idx, w_cntOff, 1'b0};
        o_mem_wdata = w_arrLine[w_cntOff];
        if (r_cnt == LAST_WORD) w_nextState = S_FILL;
      end
      S_FILL: begin
        o_stall = 1'b1;
        if (r_cnt <= LAST_WORD) begin
          o_mem_rd   = 1'b1;
          o_mem_addr = {r_tag, r_idx, w_cntOff, 1'b0};
        end
        if (r_cnt >= LAT_CNT) begin
          w_wordWe = 1'b1;
          w_wrOff  = w_fillOff;
          w_wrData = i_mem_rdata;
        end
        if (r_cnt == FILL_LAST) begin
          w_metaWe    = 1'b1;
          w_metaTag   = r_tag;
          w_metaValid = 1'b1;
          w_nextState = S_FINISH;
        end
      end
      S_FINISH: begin
        o_done = 1'b1;
        if (r_isWr) begin
          w_wordWe    = 1'b1;
          w_wrOff     = r_off;
          w_wrData    = r_wdata;
          w_metaWe    = 1'b1;
          w_metaTag   = r_tag;
          w_metaValid = 1'b1;
          w_metaDirty = 1'b1;
        end else begin
          o_rdata = w_arrLine[r_off];
        end
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // cnt restarts from zero on every state entry and idles at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_off   <= '0;
      r_wdata <= '0;
      r_isWr  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
      if (w_miss) begin
        r_tag   <= w_inTag;
        r_idx   <= w_inIdx;
        r_off   <= w_inOff;
        r_wdata <= i_wdata;
        r_isWr  <= i_wr;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses, queued expectations, negedge monitor.
module tb_dcache_ctrl;

  typedef struct {
    logic [15:0] rdata;
    logic        chkData;
    logic        hit;
    logic        err;
    int          doneCycle;
    int          stalls;
  } resp_t;

  typedef struct {
    logic        isWr;
    logic [15:0] addr;
    logic [15:0] data;
  } memTxn_t;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd;
  logic        wr;
  logic [15:0] rdata;
  logic        done;
  logic        stall;
  logic        hit;
  logic        err;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memRd;
  logic        memWr;
  logic [15:0] memRdata;

  logic [15:0] mem [256];
  logic [15:0] rdPipe1;
  logic [15:0] rdPipe2;

  resp_t   respQ[$];
  memTxn_t memQ[$];
  int      checks;
  int      passes;
  int      cycleCnt;
  int      stallCnt;

  dcache_ctrl #(
    .IDX_W  (3),
    .RD_LAT (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_rd        (rd),
    .i_wr        (wr),
    .o_rdata     (rdata),
    .o_done      (done),
    .o_stall     (stall),
    .o_hit       (hit),
    .o_err       (err),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_mem_rd    (memRd),
    .o_mem_wr    (memWr),
    .i_mem_rdata (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt = cycleCnt + 1;

  // Main memory: zero-latency write, two-stage pipelined read.
  always @(posedge clk) begin
    if (memWr) mem[memAddr[8:1]] <= memWdata;
    rdPipe1 <= mem[memAddr[8:1]];
    rdPipe2 <= rdPipe1;
  end
  assign memRdata = rdPipe2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) passes = passes + 1;
    else $display("[TB] FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
  endtask

  task automatic expectMem(input logic isWr, input logic [15:0] a, input logic [15:0] d);
    memTxn_t t;
    t.isWr = isWr;
    t.addr = a;
    t.data = d;
    memQ.push_back(t);
  endtask

  task automatic expectFill(input logic [15:0] base);
    for (int i = 0; i < 4; i++) expectMem(1'b0, base + 16'(2 * i), 16'h0);
  endtask

  task automatic expectEvict(input logic [15:0] base, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
    expectMem(1'b1, base,          d0);
    expectMem(1'b1, base + 16'h2,  d1);
    expectMem(1'b1, base + 16'h4,  d2);
    expectMem(1'b1, base + 16'h6,  d3);
  endtask

  // Called at posedge+1; holds the request until done, then releases it.
  task automatic applyStimulus(input logic rdIn, input logic wrIn, input logic [15:0] addrIn,
                               input logic [15:0] wdataIn, input logic [15:0] expRdata,
                               input logic chkData, input logic expHit, input logic expErr,
                               input int lat, input int stalls);
    resp_t e;
    bit    seen;
    e.rdata     = expRdata;
    e.chkData   = chkData;
    e.hit       = expHit;
    e.err       = expErr;
    e.doneCycle = cycleCnt + lat;
    e.stalls    = stalls;
    respQ.push_back(e);
    rd    = rdIn;
    wr    = wrIn;
    addr  = addrIn;
    wdata = wdataIn;
    seen  = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) checkOutput("done_timeout", {31'b0, done}, 32'h1);
    @(posedge clk);
    #1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 16'h0;
    wdata = 16'h0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a memory access or done.
  always @(negedge clk) begin
    memTxn_t t;
    resp_t   e;
    if (rst) begin
      stallCnt = 0;
    end else begin
      if (memRd || memWr) begin
        if (memQ.size() == 0) begin
          checkOutput("mem_unexpected", {30'b0, memRd, memWr}, 32'h0);
        end else begin
          t = memQ.pop_front();
          checkOutput("mem_is_wr", {31'b0, memWr}, {31'b0, t.isWr});
          checkOutput("mem_addr", {16'b0, memAddr}, {16'b0, t.addr});
          if (t.isWr) checkOutput("mem_wdata", {16'b0, memWdata}, {16'b0, t.data});
        end
      end
      if (stall) stallCnt = stallCnt + 1;
      if (done) begin
        if (respQ.size() == 0) begin
          checkOutput("done_unexpected", {31'b0, done}, 32'h0);
        end else begin
          e = respQ.pop_front();
          checkOutput("done_cycle", cycleCnt, e.doneCycle);
          checkOutput("stall_cycles", stallCnt, e.stalls);
          checkOutput("stall_at_done", {31'b0, stall}, 32'h0);
          checkOutput("hit", {31'b0, hit}, {31'b0, e.hit});
          checkOutput("err", {31'b0, err}, {31'b0, e.err});
          if (e.chkData) checkOutput("rdata", {16'b0, rdata}, {16'b0, e.rdata});
        end
        stallCnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    passes   = 0;
    cycleCnt = 0;
    stallCnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 2) ^ 16'h5A5A;
    mem[8] = 16'hBEEF;
    rst   = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 16'h0;
    wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctl", {26'b0, done, stall, hit, err, memRd, memWr}, 32'h0);
    checkOutput("reset_bus", {rdata, memAddr}, 32'h0);
    checkOutput("reset_wdata", {16'b0, memWdata}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] cold load, repeat hit");
    expectFill(16'h0010);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0,    16'hBEEF, 1'b1, 1'b0, 1'b0, 7, 7);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0,    16'hBEEF, 1'b1, 1'b1, 1'b0, 0, 0);

    $display("[TB] store hit, then dirty eviction");
    applyStimulus(1'b0, 1'b1, 16'h0012, 16'h1234, 16'h0,    1'b0, 1'b1, 1'b0, 0, 0);
    expectEvict(16'h0010, 16'hBEEF, 16'h1234, 16'h5A4E, 16'h5A4C);
    expectFill(16'h0050);
    applyStimulus(1'b1, 1'b0, 16'h0050, 16'h0,    16'h5A0A, 1'b1, 1'b0, 1'b0, 11, 11);

    $display("[TB] error requests");
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0,    16'h0,    1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b1, 1'b1, 16'h0050, 16'h9999, 16'h0,    1'b0, 1'b0, 1'b1, 0, 0);
    applyStimulus(1'b1, 1'b0, 16'h0052, 16'h0,    16'h5A08, 1'b1, 1'b1, 1'b0, 0, 0);

    $display("[TB] reset during fill");
    expectMem(1'b0, 16'h0010, 16'h0);
    expectMem(1'b0, 16'h0012, 16'h0);
    expectMem(1'b0, 16'h0014, 16'h0);
    rd   = 1'b1;
    addr = 16'h0010;
    repeat (4) @(posedge clk);
    #1;
    rst  = 1'b1;
    rd   = 1'b0;
    addr = 16'h0;
    #1;
    checkOutput("midfill_rst_ctl", {26'b0, done, stall, hit, err, memRd, memWr}, 32'h0);
    checkOutput("midfill_rst_bus", {rdata, memAddr}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expectFill(16'h0010);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0,    16'hBEEF, 1'b1, 1'b0, 1'b0, 7, 7);
    applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0,    16'h1234, 1'b1, 1'b1, 1'b0, 0, 0);

    $display("[TB] store miss, merge, write-back");
    expectFill(16'h0020);
    applyStimulus(1'b0, 1'b1, 16'h0020, 16'hCAFE, 16'h0,    1'b0, 1'b0, 1'b0, 7, 7);
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0,    16'hCAFE, 1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 16'h0022, 16'h7777, 16'h0,    1'b0, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 16'h0022, 16'h0,    16'h7777, 1'b1, 1'b1, 1'b0, 0, 0);
    expectEvict(16'h0020, 16'hCAFE, 16'h7777, 16'h5A7E, 16'h5A7C);
    expectFill(16'h0060);
    applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0,    16'h5A3A, 1'b1, 1'b0, 1'b0, 11, 11);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_outputs", {26'b0, done, stall, hit, err, memRd, memWr}, 32'h0);
    checkOutput("resp_queue_drained", respQ.size(), 32'h0);
    checkOutput("mem_queue_drained", memQ.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
